// File: rtl/adder32_arbiter.sv
// adder32_arbiter: two requesters share one 33-bit adder through a
// one-entry result slot. Arbitration is round-robin (RR_EN = 1) or fixed
// priority with requester 0 highest (RR_EN = 0). Each requester owns a
// saved carry so it can chain multi-word additions independently.
module adder32_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req0_carry_i,
    input  logic        req0_chain_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic        req1_carry_i,
    input  logic        req1_chain_i,

    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_sum_o,
    output logic        res_carry_o,
    output logic        res_id_o,
    output logic        busy_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Shared 33-bit adder: {carry, sum} = a + b + cin
    function automatic logic [32:0] add33(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;

    logic        last_grant_r;
    logic [1:0]  saved_carry_r;
    logic [31:0] res_sum_r;
    logic        res_carry_r;
    logic        res_id_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        slot_free_s;
    logic        ready0_s;
    logic        ready1_s;
    logic        accept_s;
    logic [31:0] a_sel_s;
    logic [31:0] b_sel_s;
    logic        cin_sel_s;
    logic [32:0] add_s;

    // Arbitration: depends only on valids and last_grant, never on ready
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            if ((RR_EN == 1'b1) && (last_grant_r == 1'b0)) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (req0_valid_i) begin
            grant0_s = 1'b1;
        end else if (req1_valid_i) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // State register of the result-slot FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM output logic: slot availability and per-requester ready
    always_comb begin
        slot_free_s = 1'b0;
        case (state_r)
            ST_EMPTY: slot_free_s = 1'b1;
            ST_FULL:  slot_free_s = res_ready_i;
            default:  slot_free_s = 1'b0;
        endcase
        // Ready is held low while reset is asserted
        ready0_s = rst_ni & slot_free_s & grant0_s;
        ready1_s = rst_ni & slot_free_s & grant1_s;
        accept_s = ready0_s | ready1_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else if (res_ready_i) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Operand mux steered by the grant, carry-in from chain or explicit input
    always_comb begin
        if (grant1_s) begin
            a_sel_s   = req1_a_i;
            b_sel_s   = req1_b_i;
            cin_sel_s = req1_chain_i ? saved_carry_r[1] : req1_carry_i;
        end else begin
            a_sel_s   = req0_a_i;
            b_sel_s   = req0_b_i;
            cin_sel_s = req0_chain_i ? saved_carry_r[0] : req0_carry_i;
        end
        add_s = add33(a_sel_s, b_sel_s, cin_sel_s);
    end

    // Result slot, saved carries and last_grant update on accepted transfers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_sum_r     <= 32'd0;
            res_carry_r   <= 1'b0;
            res_id_r      <= 1'b0;
            saved_carry_r <= 2'b00;
            last_grant_r  <= 1'b1;
        end else if (accept_s) begin
            res_sum_r    <= add_s[31:0];
            res_carry_r  <= add_s[32];
            res_id_r     <= ready1_s;
            last_grant_r <= ready1_s;
            if (ready1_s) begin
                saved_carry_r[1] <= add_s[32];
            end else begin
                saved_carry_r[0] <= add_s[32];
            end
        end else begin
            res_sum_r     <= res_sum_r;
            res_carry_r   <= res_carry_r;
            res_id_r      <= res_id_r;
            saved_carry_r <= saved_carry_r;
            last_grant_r  <= last_grant_r;
        end
    end

    assign req0_ready_o = ready0_s;
    assign req1_ready_o = ready1_s;
    assign res_valid_o  = (state_r == ST_FULL);
    assign busy_o       = (state_r == ST_FULL);
    assign res_sum_o    = res_sum_r;
    assign res_carry_o  = res_carry_r;
    assign res_id_o     = res_id_r;

endmodule

// File: tb/tb_adder32_arbiter.sv
// Testbench for adder32_arbiter: directed scenarios plus randomized traffic,
// with a reference model producing expected results into a scoreboard queue
// and a separate monitor checking whatever the DUT presents.
module tb_adder32_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_carry, req0_chain, req1_carry, req1_chain;
    logic        res_valid, res_ready, res_carry, res_id, busy;
    logic [31:0] res_sum;

    // Fixed-priority instance sharing the same inputs
    logic        fp_ready0, fp_ready1, fp_valid, fp_carry, fp_id, fp_busy;
    logic [31:0] fp_sum;

    adder32_arbiter #(.RR_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req0_carry_i(req0_carry), .req0_chain_i(req0_chain),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b),
        .req1_carry_i(req1_carry), .req1_chain_i(req1_chain),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_sum_o(res_sum), .res_carry_o(res_carry),
        .res_id_o(res_id), .busy_o(busy)
    );

    adder32_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid), .req0_ready_o(fp_ready0),
        .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req0_carry_i(req0_carry), .req0_chain_i(req0_chain),
        .req1_valid_i(req1_valid), .req1_ready_o(fp_ready1),
        .req1_a_i(req1_a), .req1_b_i(req1_b),
        .req1_carry_i(req1_carry), .req1_chain_i(req1_chain),
        .res_valid_o(fp_valid), .res_ready_i(res_ready),
        .res_sum_o(fp_sum), .res_carry_o(fp_carry),
        .res_id_o(fp_id), .busy_o(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        id;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    logic m_full;
    logic m_last;
    logic m_saved [0:1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_full     = 1'b0;
        m_last     = 1'b1;
        m_saved[0] = 1'b0;
        m_saved[1] = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // One clock cycle of stimulus; the model predicts the grant and result
    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic c0, input logic ch0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic c1, input logic ch1,
                         input logic rr, output logic g0, output logic g1);
        logic        free;
        logic        cin;
        logic [32:0] t;
        res_t        r;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_carry = c0; req0_chain = ch0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_carry = c1; req1_chain = ch1;
        res_ready  = rr;
        #1;
        free = !m_full || rr;
        g0 = 1'b0;
        g1 = 1'b0;
        if (free) begin
            if (v0 && v1) begin
                if (m_last) g0 = 1'b1;
                else        g1 = 1'b1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check("ready0", req0_ready, g0);
        check("ready1", req1_ready, g1);
        check("res_valid", res_valid, m_full);
        check("busy", busy, m_full);
        if (rr) begin
            check("fp_ready0", fp_ready0, v0);
            check("fp_ready1", fp_ready1, v1 && !v0);
        end
        @(posedge clk);
        if (g0 || g1) begin
            if (g1) begin
                cin = ch1 ? m_saved[1] : c1;
                t   = {1'b0, a1} + {1'b0, b1} + {32'd0, cin};
            end else begin
                cin = ch0 ? m_saved[0] : c0;
                t   = {1'b0, a0} + {1'b0, b0} + {32'd0, cin};
            end
            r.sum   = t[31:0];
            r.carry = t[32];
            r.id    = g1;
            exp_q.push_back(r);
            if (g1) m_saved[1] = t[32];
            else    m_saved[0] = t[32];
            m_last = g1;
            m_full = 1'b1;
        end else if (rr) begin
            m_full = 1'b0;
        end
    endtask

    task automatic check_res(input string name, input logic [31:0] s, input logic c, input logic id);
        #1;
        check({name, "_valid"}, res_valid, 1'b1);
        check({name, "_sum"}, res_sum, s);
        check({name, "_carry"}, res_carry, c);
        check({name, "_id"}, res_id, id);
    endtask

    // Monitor: compare the presented result against the scoreboard head
    always @(negedge clk) begin
        #3;
        if (rst_ni && res_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1'b1, 1'b0);
            end else begin
                check("mon_sum", res_sum, exp_q[0].sum);
                check("mon_carry", res_carry, exp_q[0].carry);
                check("mon_id", res_id, exp_q[0].id);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        g0, g1;
    logic        pv  [0:1];
    logic [31:0] pa  [0:1];
    logic [31:0] pb  [0:1];
    logic        pc  [0:1];
    logic        pch [0:1];
    logic        rr;
    logic [31:0] ha0, hb0, ha1, hb1;

    initial begin
        model_reset();
        rst_ni = 1'b0;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_carry = 1'b0; req0_chain = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h3; req1_b = 32'h4; req1_carry = 1'b0; req1_chain = 1'b0;
        #12;
        check("rst_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", res_sum, 32'h0);
        check("rst_carry", res_carry, 1'b0);
        check("rst_id", res_id, 1'b0);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;

        // Single op with carry-out
        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        check_res("single", 32'h0, 1'b1, 1'b0);

        // 64-bit chain on requester 1
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, g0, g1);
        check_res("chain_lo", 32'h0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, g0, g1);
        check_res("chain_hi", 32'h1, 1'b0, 1'b1);

        // Chain isolation: req0 carry does not leak into req1
        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        check_res("iso_r0", 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, g0, g1);
        check_res("iso_r1", 32'h0, 1'b0, 1'b1);

        // Contention: alternating grants, one result per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, g0, g1);
            #1;
            check("rr_id", res_id, i % 2);
        end

        // Backpressure: hold both requests while the consumer stalls
        ha0 = $urandom; hb0 = $urandom; ha1 = $urandom; hb1 = $urandom;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ha0, hb0, 1'b0, 1'b0, 1'b1, ha1, hb1, 1'b0, 1'b0, 1'b0, g0, g1);
        end
        drive(1'b1, ha0, hb0, 1'b0, 1'b0, 1'b1, ha1, hb1, 1'b0, 1'b0, 1'b1, g0, g1);
        check_res("bp_resume", ha0 + hb0, ({1'b0, ha0} + {1'b0, hb0}) >> 32, 1'b0);

        // Randomized traffic
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int it = 0; it < 1500; it++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        pv[k]  = 1'b1;
                        pa[k]  = rnd_word();
                        pb[k]  = rnd_word();
                        pc[k]  = 1'($urandom_range(0, 1));
                        pch[k] = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pv[k] = 1'b0;
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            drive(pv[0], pa[0], pb[0], pc[0], pch[0], pv[1], pa[1], pb[1], pc[1], pch[1], rr, g0, g1);
            if (g0) pv[0] = 1'b0;
            if (g1) pv[1] = 1'b0;
        end

        // Drain the slot
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        end
        check("drained", exp_q.size(), 0);

        // Reset while FULL, with requester 0's saved carry set
        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        check_res("pre_rst", 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h0; req0_b = 32'h0; req0_chain = 1'b1;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", res_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready0", req0_ready, 1'b0);
        check("midrst_sum", res_sum, 32'h0);
        check("midrst_carry", res_carry, 1'b0);
        model_reset();
        req0_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_ni = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        check_res("post_rst", 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, g0, g1);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
